rs232_receiver: RTL and testbench
=================================

# rs232_receiver

Serial receive front end for the PicoBlaze UART path: samples the asynchronous `rs232_rx` line with 16x oversampling and frames 8N1 characters. Valid bytes go into a first-word-fall-through FIFO, which the CPU port-decode logic drains through the `rx_data_out` / `rx_data_present` / `read_rx_data_ack` handshake. Framing and overrun errors are reported as sticky status bits readable on a spare input port.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency.
- `BAUD`, 115200, line rate.
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, at least 2.
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rs232_rx` in 1: raw serial input, idle high, asynchronous to `clk`.
- `rx_data_out` out 8: FIFO head byte; valid while `rx_data_present`=1.
- `rx_data_present` out 1: FIFO not empty.
- `read_rx_data_ack` in 1: single-cycle pop strobe.
- `rx_half_full` out 1: occupancy ≥ `FIFO_DEPTH`/2.
- `rx_full` out 1: occupancy = `FIFO_DEPTH`.
- `rx_overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `rx_frame_err` out 1: sticky; a stop bit was sampled low.
- `clear_errors` in 1: single-cycle strobe; clears both sticky flags.

## Operation
- Input path: `rs232_rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator:
  - Divisor = round(`CLK_FREQ_HZ` / (`BAUD`·16)), which is 27 at the defaults.
  - The counter emits a one-cycle `tick` at the end of each divisor period.
  - The counter free-runs and is not resynchronized to the start edge. The resulting ±1/16-bit sampling jitter is accepted.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE. The sample counter is 4 bits; the bit counter is 3 bits.
- IDLE: when the synchronized line reads 0 → START, and the sample counter clears.
- START: count ticks. At tick 8 (mid start bit):
  - line 1 → IDLE (glitch rejected);
  - line 0 → DATA, with the sample counter and bit counter cleared.
- DATA:
  - Sample at every 16th tick, i.e. mid-bit. Shift LSB first into an 8-bit shift register.
  - After the 8th bit → STOP.
- STOP: at the 16th tick, sample the line.
  - Line 1, FIFO not full → push the byte, then IDLE.
  - Line 1, FIFO full, no pop this cycle → drop the byte, set `rx_overrun`, then IDLE.
  - Line 1, FIFO full, pop this cycle → push succeeds; no overrun.
  - Line 0 → discard the byte, set `rx_frame_err`, then WAIT_IDLE.
- WAIT_IDLE: stay until the synchronized line reads 1, then IDLE. This prevents a break condition from producing repeated frames.
- FIFO:
  - Read and write pointers are `$clog2(FIFO_DEPTH)` bits, wrapping modulo depth. Occupancy is `$clog2(FIFO_DEPTH)`+1 bits.
  - `read_rx_data_ack` while empty is ignored; pointers and occupancy are unchanged.
  - Simultaneous push and pop leaves occupancy unchanged.
- Sticky flags: if a set condition and `clear_errors` occur in the same cycle, set wins.

## Timing
- Reset values: `rx_data_out`=0x00; `rx_data_present`, `rx_half_full`, `rx_full`, `rx_overrun` and `rx_frame_err` all 0; FIFO empty.
- `rx_data_out` is driven combinationally from the head entry and shows 0x00 when empty.
- Byte latency: `rx_data_present` rises on the cycle after the STOP-sample tick. That is about 2 sync cycles plus 9.5 bit times after the start-bit falling edge at the pin.
- Pop: after an ack cycle, the next head byte (or `rx_data_present`=0) is visible on the following cycle.
- `rx_full` and `rx_half_full` update on the cycle after the push or pop.
- Back-to-back frames: a start edge arriving on the cycle after the STOP sample is accepted.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is flushed and flags are cleared, all immediately (asynchronous). The partial frame is lost. Reception resumes at the next falling edge after reset deassertion.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum;
  - `OVERSAMPLE`=16;
  - a divisor-computing function, also used by the transmit side.
- Sub-module `byte_fifo`: parameterized FWFT FIFO with push, pop, dout, empty, full, half_full and count. `rs232_receiver` instantiates it once.

## Test plan
Defaults throughout: divisor 27, one bit = 432 clocks.
- Send 0x55 (8N1) → `rx_data_present`=1, `rx_data_out`=0x55. One-cycle ack → `rx_data_present`=0 on the next cycle.
- Pull the line low for 100 clocks, then release → no push, FSM back in IDLE, no flags set.
- Send 0xA3 with the stop bit low → `rx_frame_err`=1, FIFO empty. Hold low for 20 bit times, release, send 0x3C → 0x3C received. Strobe `clear_errors` → flag=0.
- Send 0x00..0x10 (17 bytes) without ack → `rx_half_full` after 8 bytes, `rx_full` after 16, `rx_overrun`=1. Draining returns 0x00..0x0F; 0x10 is lost.
- FIFO full; assert ack on the same cycle as the next frame's push → occupancy stays 16, `rx_overrun` stays 0, the new byte is read last.
- Assert `reset` during DATA bit 4 of a frame → all outputs reset values immediately. After release, send 0xC9 → exactly one byte 0xC9 received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the serial receive/transmit paths: the receiver
// framing states, the oversampling ratio and the baud-divisor helper.

package uart_pkg;

   // Each bit period is split into this many baud-tick samples.
   localparam int OVERSAMPLE = 16;

   // Receiver framing states.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rxState_t;

   // Clocks per oversample tick, rounded to the nearest integer.
   // 64-bit arithmetic keeps fast clocks with high baud rates from overflowing.
   function automatic int calcDivisor(input longint clkHz, input longint baud);
      longint denom;
      denom = baud * longint'(OVERSAMPLE);
      return int'((clkHz + (denom / 2)) / denom);
   endfunction

endpackage

// File: rtl/rs232_receiver_if.sv
// rs232_receiver_if
// Bundles the serial line, the CPU-side FIFO read handshake and the sticky
// error status of the receiver.
// The slave modport is the receiver side.
// The master modport is the side that drives the line and drains the FIFO.

interface rs232_receiver_if;

   logic       rs232_rx;
   logic [7:0] rx_data_out;
   logic       rx_data_present;
   logic       read_rx_data_ack;
   logic       rx_half_full;
   logic       rx_full;
   logic       rx_overrun;
   logic       rx_frame_err;
   logic       clear_errors;

   modport master (
      output rs232_rx,
      output read_rx_data_ack,
      output clear_errors,
      input  rx_data_out,
      input  rx_data_present,
      input  rx_half_full,
      input  rx_full,
      input  rx_overrun,
      input  rx_frame_err
   );

   modport slave (
      input  rs232_rx,
      input  read_rx_data_ack,
      input  clear_errors,
      output rx_data_out,
      output rx_data_present,
      output rx_half_full,
      output rx_full,
      output rx_overrun,
      output rx_frame_err
   );

endinterface

// File: rtl/byte_fifo.sv
// byte_fifo
// First-word-fall-through FIFO: the head entry is visible on o_dout while
// the FIFO is not empty, and reads as zero when the FIFO is empty.
// A pop while empty is ignored. A push while full is ignored unless a pop
// happens in the same cycle; that pop frees the slot being written.
// DEPTH must be a power of two so the pointers wrap naturally.

module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_din,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_empty,
   output logic                       o_full,
   output logic                       o_halfFull,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_CNT = CW'(DEPTH / 2);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [CW-1:0]    r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == FULL_CNT);
   assign o_halfFull = (r_count >= HALF_CNT);
   assign o_count    = r_count;
   assign o_dout     = o_empty ? '0 : r_mem[r_rdPtr];

   // Qualify the strobes: popping needs data, pushing needs room (or a pop).
   always_comb begin
      w_doPop  = i_pop && !o_empty;
      w_doPush = i_push && (!o_full || w_doPop);
   end

   // Storage array; left unreset because the occupancy count says what is valid.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_din;
      end
   end

   // Pointer and occupancy bookkeeping; push and pop together leave the count alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + CW'(1);
         end else if (w_doPop && !w_doPush) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/rs232_receiver.sv
// rs232_receiver
// 8N1 serial receive front end with 16x oversampling, feeding a
// first-word-fall-through byte FIFO that the CPU drains through an ack
// strobe. Framing and overrun errors are kept as sticky status flags.

module rs232_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 16
) (
   input logic             clk,
   input logic             reset,
   rs232_receiver_if.slave bus
);

   localparam int DIV = calcDivisor(longint'(CLK_FREQ_HZ), longint'(BAUD));
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

   // Line synchronizer and baud tick.
   logic          r_sync1;
   logic          r_sync2;
   logic          w_rx;
   logic [TW-1:0] r_tickCnt;
   logic          w_tick;

   // Framing state machine.
   rxState_t      r_state;
   rxState_t      w_stateNext;
   logic [3:0]    r_sampleCnt;
   logic [3:0]    w_sampleCntNext;
   logic [2:0]    r_bitCnt;
   logic [2:0]    w_bitCntNext;
   logic [7:0]    r_shift;
   logic [7:0]    w_shiftNext;

   // FIFO hookup and status.
   logic          w_push;
   logic          w_setOverrun;
   logic          w_setFrameErr;
   logic          w_fifoHasRoom;
   logic [CW-1:0] w_fifoCount;
   logic          w_fifoEmpty;
   logic          w_fifoFull;
   logic          w_fifoHalfFull;
   logic [7:0]    w_fifoDout;
   logic          r_overrun;
   logic          r_frameErr;

   assign w_rx = r_sync2;

   // Two-flop synchronizer; both flops reset to the idle (mark) level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.rs232_rx;
         r_sync2 <= r_sync1;
      end
   end

   // Free-running oversample divider. It is deliberately not realigned to the
   // start edge, so a sample can land up to one tick off the ideal mid-bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tickCnt <= '0;
      end else if (r_tickCnt == TICK_LAST) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + TW'(1);
      end
   end

   assign w_tick = (r_tickCnt == TICK_LAST);

   // A byte can still go in when the FIFO is full if the CPU pops in the same
   // cycle; a full FIFO is never empty, so the ack alone means a real pop.
   assign w_fifoHasRoom = (w_fifoCount != FULL_CNT) || bus.read_rx_data_ack;

   // Framing state register and its counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_sampleCnt <= '0;
         r_bitCnt    <= '0;
         r_shift     <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_sampleCnt <= w_sampleCntNext;
         r_bitCnt    <= w_bitCntNext;
         r_shift     <= w_shiftNext;
      end
   end

   // Next-state logic. START confirms the start bit at its middle (tick 8).
   // DATA and STOP then sample every 16th tick, which lands mid-bit.
   // A low stop bit parks in WAIT_IDLE, so a held break yields one error, not a stream.
   always_comb begin
      w_stateNext     = r_state;
      w_sampleCntNext = r_sampleCnt;
      w_bitCntNext    = r_bitCnt;
      w_shiftNext     = r_shift;
      w_push          = 1'b0;
      w_setOverrun    = 1'b0;
      w_setFrameErr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rx) begin
               w_stateNext     = START;
               w_sampleCntNext = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (r_sampleCnt == 4'd7) begin
                  if (w_rx) begin
                     w_stateNext = IDLE;
                  end else begin
                     w_stateNext     = DATA;
                     w_sampleCntNext = '0;
                     w_bitCntNext    = '0;
                  end
               end else begin
                  w_sampleCntNext = r_sampleCnt + 4'd1;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               w_sampleCntNext = r_sampleCnt + 4'd1;
               if (r_sampleCnt == 4'd15) begin
                  w_shiftNext  = {w_rx, r_shift[7:1]};
                  w_bitCntNext = r_bitCnt + 3'd1;
                  if (r_bitCnt == 3'd7) begin
                     w_stateNext = STOP;
                  end
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               w_sampleCntNext = r_sampleCnt + 4'd1;
               if (r_sampleCnt == 4'd15) begin
                  if (w_rx) begin
                     w_stateNext = IDLE;
                     if (w_fifoHasRoom) begin
                        w_push = 1'b1;
                     end else begin
                        w_setOverrun = 1'b1;
                     end
                  end else begin
                     w_stateNext   = WAIT_IDLE;
                     w_setFrameErr = 1'b1;
                  end
               end
            end
         end
         WAIT_IDLE: begin
            if (w_rx) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Sticky error flags; a new error in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overrun  <= 1'b0;
         r_frameErr <= 1'b0;
      end else begin
         if (w_setOverrun) begin
            r_overrun <= 1'b1;
         end else if (bus.clear_errors) begin
            r_overrun <= 1'b0;
         end
         if (w_setFrameErr) begin
            r_frameErr <= 1'b1;
         end else if (bus.clear_errors) begin
            r_frameErr <= 1'b0;
         end
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_pop      (bus.read_rx_data_ack),
      .i_din      (r_shift),
      .o_dout     (w_fifoDout),
      .o_empty    (w_fifoEmpty),
      .o_full     (w_fifoFull),
      .o_halfFull (w_fifoHalfFull),
      .o_count    (w_fifoCount)
   );

   assign bus.rx_data_out     = w_fifoDout;
   assign bus.rx_data_present = !w_fifoEmpty;
   assign bus.rx_full         = w_fifoFull;
   assign bus.rx_half_full    = w_fifoHalfFull;
   assign bus.rx_overrun      = r_overrun;
   assign bus.rx_frame_err    = r_frameErr;

endmodule

// File: tb/tb_rs232_receiver.sv
// tb_rs232_receiver
// Self-checking bench for rs232_receiver.
// The clock is scaled so the divisor rounds (8.5 MHz / (115200*16) = 4.61 -> 5),
// which gives one bit = 80 clocks and keeps long FIFO sequences short.
// Frames are driven cycle by cycle. Bytes expected in the FIFO go into a
// scoreboard queue as they are sent and are compared as the FIFO is drained.

module tb_rs232_receiver;

   localparam int CLK_FREQ_HZ = 8_500_000;
   localparam int BAUD        = 115200;
   localparam int FIFO_DEPTH  = 16;
   localparam int TB_DIV      = 5;
   localparam int BIT_CYC     = TB_DIV * 16;

   typedef struct {
      byte unsigned data;
      bit           stopBit;
      int           holdLowBits;
      bit           expStored;
      bit           expFrameErr;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   int           checks = 0;
   int           failures = 0;
   int           cyc;
   byte unsigned expQ[$];
   vec_t         vecs[6];

   rs232_receiver_if bus();

   rs232_receiver #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Posedges since reset release, mirroring the free-running tick phase.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame. With ackAtPush, pulse the ack exactly in the cycle
   // whose posedge registers the stop-bit decision. The start edge lands at
   // posedge m and is seen by the FSM two posedges later. The 152nd tick after
   // that is the stop sample, and ticks fall on posedges that are multiples of TB_DIV.
   task automatic applyStimulus(input byte unsigned data, input bit stopBit, input bit store,
                                input bit ackAtPush, input int abortAt);
      logic [9:0] frame;
      int m;
      int p1;
      int pAck;
      frame = {stopBit, data, 1'b0};
      m = 0;
      pAck = 0;
      if (store) expQ.push_back(data);
      for (int c = 0; c < 10 * BIT_CYC; c++) begin
         @(negedge clk);
         if (c == abortAt) return;
         if (c == 0) begin
            m    = cyc + 1;
            p1   = ((m + 3 + TB_DIV - 1) / TB_DIV) * TB_DIV;
            pAck = p1 + 151 * TB_DIV;
         end
         bus.rs232_rx = frame[c / BIT_CYC];
         if (ackAtPush && (cyc + 1 == pAck)) begin
            if (expQ.size() > 0) checkOutput("ackHead", bus.rx_data_out, expQ.pop_front());
            else                 checkOutput("ackHeadQueue", 0, 1);
            bus.read_rx_data_ack = 1'b1;
         end else begin
            bus.read_rx_data_ack = 1'b0;
         end
      end
      bus.read_rx_data_ack = 1'b0;
   endtask

   // Pop every scoreboard entry through the ack handshake, then expect empty.
   task automatic drainAndCheck();
      while (expQ.size() > 0) begin
         @(negedge clk);
         checkOutput("present", bus.rx_data_present, 1);
         if (!bus.rx_data_present) begin
            expQ.delete();
            break;
         end
         checkOutput("data", bus.rx_data_out, expQ.pop_front());
         bus.read_rx_data_ack = 1'b1;
         @(negedge clk);
         bus.read_rx_data_ack = 1'b0;
      end
      checkOutput("emptyAfterDrain", bus.rx_data_present, 0);
   endtask

   task automatic clearErrors();
      @(negedge clk);
      bus.clear_errors = 1'b1;
      @(negedge clk);
      bus.clear_errors = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int occ;
      vecs[0] = '{8'h55, 1'b1, 0,  1'b1, 1'b0};
      vecs[1] = '{8'hA3, 1'b0, 20, 1'b0, 1'b1};
      vecs[2] = '{8'h3C, 1'b1, 0,  1'b1, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0};
      vecs[4] = '{8'h00, 1'b1, 0,  1'b1, 1'b0};
      vecs[5] = '{8'h96, 1'b1, 0,  1'b1, 1'b0};

      reset = 1'b1;
      bus.rs232_rx = 1'b1;
      bus.read_rx_data_ack = 1'b0;
      bus.clear_errors = 1'b0;
      idle(3);
      checkOutput("rstDataOut", bus.rx_data_out, 0);
      checkOutput("rstPresent", bus.rx_data_present, 0);
      checkOutput("rstHalfFull", bus.rx_half_full, 0);
      checkOutput("rstFull", bus.rx_full, 0);
      checkOutput("rstOverrun", bus.rx_overrun, 0);
      checkOutput("rstFrameErr", bus.rx_frame_err, 0);
      reset = 1'b0;
      idle(BIT_CYC);

      // Table of single frames, good and bad.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].expStored, 1'b0, -1);
         if (vecs[i].holdLowBits > 0) idle(vecs[i].holdLowBits * BIT_CYC);
         @(negedge clk);
         checkOutput("vecPresent", bus.rx_data_present, vecs[i].expStored);
         checkOutput("vecFrameErr", bus.rx_frame_err, vecs[i].expFrameErr);
         checkOutput("vecOverrun", bus.rx_overrun, 0);
         bus.rs232_rx = 1'b1;
         idle(2 * BIT_CYC);
         drainAndCheck();
         if (vecs[i].expFrameErr) begin
            clearErrors();
            checkOutput("frameErrCleared", bus.rx_frame_err, 0);
         end
      end

      // Short low pulse is rejected at mid start bit; the next frame still works.
      @(negedge clk);
      bus.rs232_rx = 1'b0;
      idle(20);
      bus.rs232_rx = 1'b1;
      idle(2 * BIT_CYC);
      checkOutput("glitchPresent", bus.rx_data_present, 0);
      checkOutput("glitchFrameErr", bus.rx_frame_err, 0);
      checkOutput("glitchOverrun", bus.rx_overrun, 0);
      applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, -1);
      idle(BIT_CYC);
      drainAndCheck();

      // Overflow: 17 back-to-back frames, the last one is dropped.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(byte'(i), 1'b1, (i < 16), 1'b0, -1);
         occ = (i < 16) ? i + 1 : 16;
         checkOutput("ovfHalfFull", bus.rx_half_full, (occ >= FIFO_DEPTH / 2));
         checkOutput("ovfFull", bus.rx_full, (occ == FIFO_DEPTH));
         checkOutput("ovfOverrun", bus.rx_overrun, (i == 16));
      end
      idle(BIT_CYC);
      drainAndCheck();
      checkOutput("overrunSticky", bus.rx_overrun, 1);
      clearErrors();
      checkOutput("overrunCleared", bus.rx_overrun, 0);

      // Full FIFO, ack in the push cycle: byte accepted, no overrun.
      for (int i = 0; i < 16; i++) applyStimulus(byte'(8'h20 + i), 1'b1, 1'b1, 1'b0, -1);
      checkOutput("fillFull", bus.rx_full, 1);
      applyStimulus(8'h30, 1'b1, 1'b1, 1'b1, -1);
      idle(BIT_CYC);
      checkOutput("ackPushFull", bus.rx_full, 1);
      checkOutput("ackPushOverrun", bus.rx_overrun, 0);
      drainAndCheck();

      // Reset in the middle of data bit 4 with data and a flag pending.
      applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, -1);
      applyStimulus(8'hA3, 1'b0, 1'b0, 1'b0, -1);
      bus.rs232_rx = 1'b1;
      idle(2 * BIT_CYC);
      checkOutput("preRstPresent", bus.rx_data_present, 1);
      checkOutput("preRstFrameErr", bus.rx_frame_err, 1);
      applyStimulus(8'h77, 1'b1, 1'b0, 1'b0, 5 * BIT_CYC + BIT_CYC / 2);
      reset = 1'b1;
      #1;
      checkOutput("midRstDataOut", bus.rx_data_out, 0);
      checkOutput("midRstPresent", bus.rx_data_present, 0);
      checkOutput("midRstHalfFull", bus.rx_half_full, 0);
      checkOutput("midRstFull", bus.rx_full, 0);
      checkOutput("midRstOverrun", bus.rx_overrun, 0);
      checkOutput("midRstFrameErr", bus.rx_frame_err, 0);
      expQ.delete();
      bus.rs232_rx = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(BIT_CYC);
      applyStimulus(8'hC9, 1'b1, 1'b1, 1'b0, -1);
      idle(BIT_CYC);
      checkOutput("postRstFrameErr", bus.rx_frame_err, 0);
      drainAndCheck();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
